// File: rtl/ddls_initiator.sv
`default_nettype none
// ============================================================================
// Module      : ddls_initiator
// Description : Initiator end of a DDLS Valid/Ready link. A debounced button
//               press issues one request carrying the switch word, then tracks
//               the responder's busy/done handshake with a per-state timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ddls_initiator #(
    parameter int DATA_W       = 8,
    parameter int RES_W        = 4,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_n,
    input  logic [DATA_W-1:0] data_sw,
    output logic              ddls_valid,
    output logic [DATA_W-1:0] ddls_data_in,
    input  logic              ddls_ready,
    input  logic [RES_W-1:0]  ddls_data_out,
    output logic [RES_W-1:0]  result,
    output logic              result_valid,
    output logic              busy,
    output logic              timeout_err
);

    localparam int c_DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int c_TO_W = $clog2(TIMEOUT_CYC);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------------
    logic              r_btn_meta;
    logic              r_btn_sync;
    logic              r_btn_level;
    logic              r_armed;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              w_db_flip;
    logic              w_press;

    assign w_db_flip = (r_btn_sync != r_btn_level) && (r_db_cnt == c_DB_LAST);
    // A button held through reset must be seen released before it can press.
    assign w_press   = w_db_flip && r_btn_level && r_armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_meta  <= 1'b0;
            r_btn_sync  <= 1'b0;
            r_btn_level <= 1'b1;
            r_armed     <= 1'b0;
            r_db_cnt    <= '0;
        end else begin
            r_btn_meta <= btn_n;
            r_btn_sync <= r_btn_meta;
            if (r_btn_sync == r_btn_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_btn_level <= r_btn_sync;
                r_db_cnt    <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_DB_W'(1);
            end
            if (r_btn_level && r_btn_sync) begin
                r_armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_next;
    logic [c_TO_W-1:0] r_to_cnt;
    logic              w_to_expired;
    logic              w_accept;
    logic              w_capture;
    logic              w_abort;

    assign w_to_expired = (r_to_cnt == c_TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_state_next = ISSUE;
                    w_accept     = 1'b1;
                end
            end
            ISSUE: begin
                w_state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Ready must go low first so a leftover high Ready is not taken as done.
                if (!ddls_ready) begin
                    w_state_next = WAIT_DONE;
                end else if (w_to_expired) begin
                    w_state_next = IDLE;
                    w_abort      = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (ddls_ready) begin
                    w_state_next = IDLE;
                    w_capture    = 1'b1;
                end else if (w_to_expired) begin
                    w_state_next = IDLE;
                    w_abort      = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Timeout counter and held request/result registers
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_data_in;
    logic [RES_W-1:0]  r_result;
    logic              r_result_valid;
    logic              r_timeout_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt       <= '0;
            r_data_in      <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            if (w_state_next != r_state) begin
                r_to_cnt <= '0;
            end else if (!w_to_expired) begin
                r_to_cnt <= r_to_cnt + c_TO_W'(1);
            end
            if (w_accept) begin
                r_data_in      <= data_sw;
                r_result_valid <= 1'b0;
                r_timeout_err  <= 1'b0;
            end
            if (w_capture) begin
                r_result       <= ddls_data_out;
                r_result_valid <= 1'b1;
            end
            if (w_abort) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign ddls_valid   = (r_state == ISSUE);
    assign busy         = (r_state != IDLE);
    assign ddls_data_in = r_data_in;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_ddls_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddls_initiator
// Description : Directed scoreboard bench for ddls_initiator (DEBOUNCE_CYC=4,
//               TIMEOUT_CYC=16) with a hand-driven responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddls_initiator;

    logic       clk;
    logic       rst;
    logic       btn_n;
    logic [7:0] data_sw;
    logic       ddls_valid;
    logic [7:0] ddls_data_in;
    logic       ddls_ready;
    logic [3:0] ddls_data_out;
    logic [3:0] result;
    logic       result_valid;
    logic       busy;
    logic       timeout_err;

    ddls_initiator #(
        .DATA_W       (8),
        .RES_W        (4),
        .DEBOUNCE_CYC (4),
        .TIMEOUT_CYC  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_n         (btn_n),
        .data_sw       (data_sw),
        .ddls_valid    (ddls_valid),
        .ddls_data_in  (ddls_data_in),
        .ddls_ready    (ddls_ready),
        .ddls_data_out (ddls_data_out),
        .result        (result),
        .result_valid  (result_valid),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [3:0] res;
        logic       rv;
        logic       te;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   pending;
    logic prev_busy;
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns at the negedge where Valid is first seen; latency counted in posedges.
    task automatic wait_valid(input string name);
        int n;
        bit seen;
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ddls_valid) seen = 1;
        end
        chk(name, 32'(n), 32'd6);
    endtask

    // Scoreboard monitor: issue data checked on each Valid, outcome on busy fall.
    initial begin
        pending   = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending   = 0;
                prev_busy = 1'b0;
            end else begin
                if (ddls_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid actual=1 required=0 data_in=%0h", ddls_data_in);
                    end else begin
                        cur     = exp_q.pop_front();
                        pending = 1;
                        chk("issue_data_in", 32'(ddls_data_in), 32'(cur.data));
                        chk("issue_busy", 32'(busy), 32'd1);
                    end
                end
                if (prev_busy && !busy && pending) begin
                    chk("done_result", 32'(result), 32'(cur.res));
                    chk("done_result_valid", 32'(result_valid), 32'(cur.rv));
                    chk("done_timeout_err", 32'(timeout_err), 32'(cur.te));
                    pending = 0;
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        btn_n         = 1'b0;
        data_sw       = 8'hFF;
        ddls_ready    = 1'b1;
        ddls_data_out = 4'h0;

        // 1: reset with button held; no request until released and pressed again
        cyc(3);
        @(negedge clk);
        chk("rst_valid", 32'(ddls_valid), 32'd0);
        chk("rst_data_in", 32'(ddls_data_in), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        cyc(1);
        rst = 1'b0;
        cyc(20);
        @(negedge clk);
        chk("held_btn_busy", 32'(busy), 32'd0);
        cyc(1);
        btn_n = 1'b1;
        cyc(10);

        // 2: normal transaction
        data_sw = 8'hB5;
        exp_q.push_back('{8'hB5, 4'h5, 1'b1, 1'b0});
        btn_n = 1'b0;
        wait_valid("t2_latency");
        cyc(1);
        ddls_ready = 1'b0;
        cyc(5);
        ddls_data_out = 4'h5;
        ddls_ready    = 1'b1;
        cyc(3);
        @(negedge clk);
        chk("t2_result", 32'(result), 32'h5);
        chk("t2_result_valid", 32'(result_valid), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        cyc(1);
        btn_n = 1'b1;
        cyc(10);

        // 3: bouncing button, then a steady hold
        data_sw = 8'h3C;
        exp_q.push_back('{8'h3C, 4'hA, 1'b1, 1'b0});
        for (int i = 0; i < 10; i++) begin
            btn_n = (i % 2 == 1);
            cyc(2);
        end
        btn_n = 1'b0;
        wait_valid("t3_bounce_latency");
        cyc(1);
        data_sw    = 8'h00;
        ddls_ready = 1'b0;
        cyc(2);
        ddls_data_out = 4'hA;
        ddls_ready    = 1'b1;
        cyc(3);
        @(negedge clk);
        chk("t3_data_in_held", 32'(ddls_data_in), 32'h3C);
        cyc(1);
        btn_n = 1'b1;
        cyc(10);

        // 4: Ready never drops -> timeout after 16 cycles in WAIT_BUSY
        data_sw = 8'h42;
        exp_q.push_back('{8'h42, 4'hA, 1'b0, 1'b1});
        btn_n = 1'b0;
        wait_valid("t4_latency");
        m = 0;
        while (busy && m < 40) begin
            @(negedge clk);
            m++;
        end
        chk("t4_timeout_cycles", 32'(m), 32'd17);
        chk("t4_result_kept", 32'(result), 32'hA);
        cyc(1);
        btn_n = 1'b1;
        cyc(10);

        // 5: press during WAIT_DONE is dropped; press after IDLE is taken
        data_sw = 8'h99;
        exp_q.push_back('{8'h99, 4'h3, 1'b1, 1'b0});
        btn_n = 1'b0;
        wait_valid("t5a_latency");
        cyc(1);
        ddls_ready = 1'b0;
        btn_n      = 1'b1;
        cyc(7);
        data_sw = 8'h66;
        btn_n   = 1'b0;
        cyc(7);
        ddls_data_out = 4'h3;
        ddls_ready    = 1'b1;
        cyc(3);
        btn_n = 1'b1;
        cyc(10);
        data_sw = 8'h17;
        exp_q.push_back('{8'h17, 4'hC, 1'b1, 1'b0});
        btn_n = 1'b0;
        wait_valid("t5b_latency");
        cyc(1);
        ddls_ready = 1'b0;
        cyc(2);
        ddls_data_out = 4'hC;
        ddls_ready    = 1'b1;
        cyc(3);
        btn_n = 1'b1;
        cyc(10);

        // 6: reset while in WAIT_DONE
        data_sw = 8'h5A;
        exp_q.push_back('{8'h5A, 4'h0, 1'b0, 1'b0});
        btn_n = 1'b0;
        wait_valid("t6_latency");
        cyc(1);
        ddls_ready = 1'b0;
        cyc(3);
        btn_n = 1'b1;
        cyc(1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(ddls_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_result_valid", 32'(result_valid), 32'd0);
        cyc(2);
        rst           = 1'b0;
        ddls_data_out = 4'h7;
        ddls_ready    = 1'b1;
        cyc(5);
        @(negedge clk);
        chk("t6_late_ready_result", 32'(result), 32'd0);
        chk("t6_late_ready_result_valid", 32'(result_valid), 32'd0);
        chk("t6_late_ready_busy", 32'(busy), 32'd0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("no_pending", 32'(pending), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
